// File: rtl/alu_control_muldiv_if.sv
// EX-stage bus between the pipeline and the ALU control / multiply-divide unit.
interface alu_control_muldiv_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 6
);
  logic                  i_valid;
  logic [OP_WIDTH-1:0]   ALUOp;
  logic [OP_WIDTH-1:0]   Funct;
  logic [DATA_WIDTH-1:0] i_rs;
  logic [DATA_WIDTH-1:0] i_rt;
  logic [OP_WIDTH-1:0]   ALUControl;
  logic                  o_use_hilo;
  logic [DATA_WIDTH-1:0] o_hilo_data;
  logic                  o_stall;
  logic                  o_busy;
  logic                  o_div_by_zero;

  modport master (
    output i_valid, ALUOp, Funct, i_rs, i_rt,
    input  ALUControl, o_use_hilo, o_hilo_data, o_stall, o_busy, o_div_by_zero
  );

  modport slave (
    input  i_valid, ALUOp, Funct, i_rs, i_rt,
    output ALUControl, o_use_hilo, o_hilo_data, o_stall, o_busy, o_div_by_zero
  );
endinterface

// File: rtl/alu_control_muldiv.sv
// EX-stage ALU control decode plus a background shift-add multiplier / restoring
// divider writing the HI/LO pair, with a HI/LO-only pipeline interlock.
module alu_control_muldiv #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 6
) (
  input logic                 clk,
  input logic                 reset,
  alu_control_muldiv_if.slave bus
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  localparam logic [OP_WIDTH-1:0] F_SLL   = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] F_SRA   = OP_WIDTH'(6'b000011);
  localparam logic [OP_WIDTH-1:0] F_SLLV  = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] F_SRAV  = OP_WIDTH'(6'b000111);
  localparam logic [OP_WIDTH-1:0] F_ADD   = OP_WIDTH'(6'b100000);
  localparam logic [OP_WIDTH-1:0] F_ADDU  = OP_WIDTH'(6'b100001);
  localparam logic [OP_WIDTH-1:0] F_SUB   = OP_WIDTH'(6'b100010);
  localparam logic [OP_WIDTH-1:0] F_SUBU  = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] F_AND   = OP_WIDTH'(6'b100100);
  localparam logic [OP_WIDTH-1:0] F_OR    = OP_WIDTH'(6'b100101);
  localparam logic [OP_WIDTH-1:0] F_XOR   = OP_WIDTH'(6'b100110);
  localparam logic [OP_WIDTH-1:0] F_NOR   = OP_WIDTH'(6'b100111);
  localparam logic [OP_WIDTH-1:0] F_SLT   = OP_WIDTH'(6'b101010);
  localparam logic [OP_WIDTH-1:0] F_SLTU  = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] F_MULT  = OP_WIDTH'(6'b011000);
  localparam logic [OP_WIDTH-1:0] F_MULTU = OP_WIDTH'(6'b011001);
  localparam logic [OP_WIDTH-1:0] F_DIV   = OP_WIDTH'(6'b011010);
  localparam logic [OP_WIDTH-1:0] F_DIVU  = OP_WIDTH'(6'b011011);
  localparam logic [OP_WIDTH-1:0] F_MFHI  = OP_WIDTH'(6'b010000);
  localparam logic [OP_WIDTH-1:0] F_MFLO  = OP_WIDTH'(6'b010010);
  localparam logic [OP_WIDTH-1:0] F_MTHI  = OP_WIDTH'(6'b010001);
  localparam logic [OP_WIDTH-1:0] F_MTLO  = OP_WIDTH'(6'b010011);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*W-1:0]    acc_q, acc_d;
  logic [W-1:0]      rem_q, rem_d;
  logic [W-1:0]      opnd_q, opnd_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [W-1:0]      hi_q, hi_d;
  logic [W-1:0]      lo_q, lo_d;
  logic              dbz_q, dbz_d;

  logic              fn_mul, fn_div, fn_signed, fn_hilo;
  logic              hilo_op, busy, issue, start, last_step;
  logic              sgn_rs, sgn_rt;
  logic [W-1:0]      mag_rs, mag_rt;
  logic [W:0]        mul_sum, div_shift, div_diff;
  logic [2*W-1:0]    step_acc, prod;
  logic [W-1:0]      step_rem, quo;
  logic [OP_WIDTH-1:0] alu_ctrl;

  // ALU control decode: R-type by funct, everything else by ALUOp class.
  always_comb begin
    alu_ctrl = '0;
    if (bus.ALUOp == '0) begin
      case (bus.Funct)
        F_SLL:   alu_ctrl = OP_WIDTH'(23);
        F_SRA:   alu_ctrl = OP_WIDTH'(28);
        F_SLLV:  alu_ctrl = OP_WIDTH'(36);
        F_SRAV:  alu_ctrl = OP_WIDTH'(15);
        F_ADD:   alu_ctrl = OP_WIDTH'(0);
        F_ADDU:  alu_ctrl = OP_WIDTH'(1);
        F_SUB:   alu_ctrl = OP_WIDTH'(2);
        F_SUBU:  alu_ctrl = OP_WIDTH'(45);
        F_AND:   alu_ctrl = OP_WIDTH'(18);
        F_OR:    alu_ctrl = OP_WIDTH'(19);
        F_XOR:   alu_ctrl = OP_WIDTH'(21);
        F_NOR:   alu_ctrl = OP_WIDTH'(20);
        F_SLT:   alu_ctrl = OP_WIDTH'(30);
        F_SLTU:  alu_ctrl = OP_WIDTH'(31);
        default: alu_ctrl = '0;
      endcase
    end else begin
      case (bus.ALUOp)
        OP_WIDTH'(1):  alu_ctrl = OP_WIDTH'(1);
        OP_WIDTH'(2):  alu_ctrl = OP_WIDTH'(0);
        OP_WIDTH'(4):  alu_ctrl = OP_WIDTH'(17);
        OP_WIDTH'(6):  alu_ctrl = OP_WIDTH'(9);
        OP_WIDTH'(7):  alu_ctrl = OP_WIDTH'(10);
        OP_WIDTH'(11): alu_ctrl = OP_WIDTH'(14);
        OP_WIDTH'(12): alu_ctrl = OP_WIDTH'(18);
        OP_WIDTH'(13): alu_ctrl = OP_WIDTH'(19);
        OP_WIDTH'(14): alu_ctrl = OP_WIDTH'(21);
        OP_WIDTH'(16): alu_ctrl = OP_WIDTH'(30);
        OP_WIDTH'(17): alu_ctrl = OP_WIDTH'(31);
        OP_WIDTH'(18): alu_ctrl = OP_WIDTH'(24);
        OP_WIDTH'(20): alu_ctrl = OP_WIDTH'(37);
        default:       alu_ctrl = '0;
      endcase
    end
  end

  // Issue qualification and operand magnitudes.
  always_comb begin
    fn_mul    = (bus.Funct == F_MULT) || (bus.Funct == F_MULTU);
    fn_div    = (bus.Funct == F_DIV)  || (bus.Funct == F_DIVU);
    fn_signed = (bus.Funct == F_MULT) || (bus.Funct == F_DIV);
    fn_hilo   = fn_mul || fn_div ||
                (bus.Funct == F_MFHI) || (bus.Funct == F_MFLO) ||
                (bus.Funct == F_MTHI) || (bus.Funct == F_MTLO);
    busy      = (state_q == ST_RUN);
    hilo_op   = bus.i_valid && (bus.ALUOp == '0) && fn_hilo;
    issue     = hilo_op && !busy;
    start     = issue && (fn_mul || fn_div);
    last_step = busy && (cnt_q == CW'(W - 1));
    sgn_rs    = fn_signed && bus.i_rs[W-1];
    sgn_rt    = fn_signed && bus.i_rt[W-1];
    mag_rs    = sgn_rs ? -bus.i_rs : bus.i_rs;
    mag_rt    = sgn_rt ? -bus.i_rt : bus.i_rt;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)     state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: interlock and MFHI/MFLO result path.
  always_comb begin
    bus.ALUControl    = alu_ctrl;
    bus.o_stall       = hilo_op && busy;
    bus.o_use_hilo    = issue && ((bus.Funct == F_MFHI) || (bus.Funct == F_MFLO));
    bus.o_hilo_data   = '0;
    if (issue && (bus.Funct == F_MFHI)) bus.o_hilo_data = hi_q;
    if (issue && (bus.Funct == F_MFLO)) bus.o_hilo_data = lo_q;
    bus.o_busy        = busy;
    bus.o_div_by_zero = dbz_q;
  end

  // One sequencer step. Multiply keeps the multiplier in the low half of acc and
  // shifts the partial product in from the top; divide shifts the dividend out of
  // acc's low half into the remainder while the quotient bits shift in behind it.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {rem_q, acc_q[W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    step_rem  = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
    if (is_div_q) step_acc = {acc_q[2*W-1:W], acc_q[W-2:0], ~div_diff[W]};
    else          step_acc = {mul_sum, acc_q[W-1:1]};
    prod = neg_res_q ? -step_acc : step_acc;
    quo  = neg_res_q ? -step_acc[W-1:0] : step_acc[W-1:0];
  end

  // Datapath next-state: operand capture, stepping, final HI/LO write-back.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = 1'b0;
    if (start) begin
      cnt_d     = '0;
      rem_d     = '0;
      is_div_d  = fn_div;
      neg_res_d = sgn_rs ^ sgn_rt;
      neg_rem_d = sgn_rs;
      if (fn_div) begin
        acc_d  = {{W{1'b0}}, mag_rs};
        opnd_d = mag_rt;
      end else begin
        acc_d  = {{W{1'b0}}, mag_rt};
        opnd_d = mag_rs;
      end
    end
    if (issue && (bus.Funct == F_MTHI)) hi_d = bus.i_rs;
    if (issue && (bus.Funct == F_MTLO)) lo_d = bus.i_rs;
    if (busy) begin
      cnt_d = cnt_q + CW'(1);
      acc_d = step_acc;
      rem_d = step_rem;
      if (last_step) begin
        cnt_d = '0;
        if (!is_div_q) begin
          hi_d = prod[2*W-1:W];
          lo_d = prod[W-1:0];
        end else begin
          // Divisor 0 leaves the dividend in the remainder; only LO needs forcing.
          hi_d = neg_rem_q ? -step_rem : step_rem;
          if (opnd_q == '0) begin
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            lo_d  = quo;
          end
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end
endmodule

// File: tb/tb_alu_control_muldiv.sv
// Bench for alu_control_muldiv: HI/LO reads are scoreboarded against an
// arithmetic reference model; decode, interlock and timing are checked inline.
module tb_alu_control_muldiv;
  localparam int unsigned W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010, F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000, F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001, F_MTLO  = 6'b010011;

  logic clk = 1'b0;
  logic reset = 1'b1;

  alu_control_muldiv_if #(.DATA_WIDTH(W), .OP_WIDTH(6)) bus ();
  alu_control_muldiv #(.DATA_WIDTH(W), .OP_WIDTH(6)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int dbz_exp = 0;
  int dbz_seen = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  logic [31:0] exp_q[$];

  int r_funct[14] = '{0, 3, 4, 7, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
  int r_code[14]  = '{23, 28, 36, 15, 0, 1, 2, 45, 18, 19, 21, 20, 30, 31};
  int i_op[13]    = '{1, 2, 4, 6, 7, 11, 12, 13, 14, 16, 17, 18, 20};
  int i_code[13]  = '{1, 0, 17, 9, 10, 14, 18, 19, 21, 30, 31, 24, 37};
  logic [5:0] ops[6] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [5:0] ref_ctrl(input logic [5:0] op, input logic [5:0] fn);
    logic [5:0] r;
    r = 6'd0;
    if (op == 6'd0) begin
      foreach (r_funct[k]) if (int'(fn) == r_funct[k]) r = 6'(r_code[k]);
    end else begin
      foreach (i_op[k]) if (int'(op) == i_op[k]) r = 6'(i_code[k]);
    end
    return r;
  endfunction

  // Architectural effect of an instruction on HI/LO, in plain arithmetic.
  task automatic model_issue(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    case (fn)
      F_MULT:  begin p = 64'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; end
      F_MULTU: begin p = {32'd0, rs} * {32'd0, rt}; hi_m = p[63:32]; lo_m = p[31:0]; end
      F_DIV, F_DIVU: begin
        if (rt == 32'd0) begin
          lo_m = '1; hi_m = rs; dbz_exp++;
        end else if (fn == F_DIV) begin
          lo_m = 32'(sa / sb); hi_m = 32'(sa % sb);
        end else begin
          lo_m = rs / rt; hi_m = rs % rt;
        end
      end
      F_MTHI:  hi_m = rs;
      F_MTLO:  lo_m = rs;
      default: ;
    endcase
  endtask

  task automatic bubble();
    bus.i_valid = 1'b0; bus.ALUOp = '0; bus.Funct = '0; bus.i_rs = '0; bus.i_rt = '0;
  endtask

  // Entered just after a rising edge; returns just after the edge that issued it.
  task automatic exec(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt,
                      output int stalls);
    bus.i_valid = 1'b1; bus.ALUOp = '0; bus.Funct = fn; bus.i_rs = rs; bus.i_rt = rt;
    if (fn == F_MFHI) exp_q.push_back(hi_m);
    if (fn == F_MFLO) exp_q.push_back(lo_m);
    stalls = 0;
    @(negedge clk);
    while (bus.o_stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (bus.o_stall) timeout_fail("issue_wait");
    model_issue(fn, rs, rt);
    @(posedge clk); #1;
    bubble();
  endtask

  task automatic read_both();
    int s;
    exec(F_MFHI, '0, '0, s);
    exec(F_MFLO, '0, '0, s);
  endtask

  task automatic dcheck(input string name, input logic [5:0] op, input logic [5:0] fn,
                        input logic [5:0] exp);
    bus.i_valid = 1'b0; bus.ALUOp = op; bus.Funct = fn;
    #1;
    check(name, 64'(bus.ALUControl), 64'(exp));
  endtask

  // Monitor: every MFHI/MFLO result the DUT presents is matched against the queue.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.o_use_hilo) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL hilo_read: unexpected read data 0x%0h", bus.o_hilo_data);
          end else begin
            e = exp_q.pop_front();
            check("hilo_read", 64'(bus.o_hilo_data), 64'(e));
          end
        end
        if (bus.o_div_by_zero) dbz_seen++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, pulses, pulse_at;
    logic [5:0] fn, op;
    logic [31:0] a, b;

    bubble();
    #12;
    check("reset_busy", 64'(bus.o_busy), 64'd0);
    check("reset_dbz", 64'(bus.o_div_by_zero), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    read_both();

    // MULT -3*7 with MFLO presented the next cycle.
    exec(F_MULT, 32'hFFFF_FFFD, 32'd7, s);
    check("mult_busy_t1", 64'(bus.o_busy), 64'd1);
    exec(F_MFLO, '0, '0, s);
    check("mflo_stall_cycles", 64'(s), 64'(W));
    check("busy_after_done", 64'(bus.o_busy), 64'd0);
    exec(F_MFHI, '0, '0, s);
    check("mfhi_no_stall", 64'(s), 64'd0);

    exec(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s);
    read_both();

    // Back-to-back multiplies.
    exec(F_MULT, 32'd12345, 32'hFFFF_0000, s);
    exec(F_MULTU, 32'h8000_0001, 32'd3, s);
    check("b2b_stall_cycles", 64'(s), 64'(W));
    read_both();

    exec(F_DIV, 32'hFFFF_FFF9, 32'd2, s);
    read_both();

    // DIVU by zero: flag high in exactly one cycle, t+W+1.
    exec(F_DIVU, 32'd7, 32'd0, s);
    pulses = 0; pulse_at = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.o_div_by_zero) begin pulses++; pulse_at = k; end
    end
    check("dbz_pulse_count", 64'(pulses), 64'd1);
    check("dbz_pulse_cycle", 64'(pulse_at), 64'(W));
    @(posedge clk); #1;
    read_both();

    exec(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, s);
    read_both();
    exec(F_DIV, 32'hFFFF_FFF0, 32'd0, s);
    read_both();

    // Non-HI/LO traffic and bubbles during a busy sequencer never stall.
    exec(F_MULT, 32'd99, 32'd101, s);
    bus.i_valid = 1'b1; bus.ALUOp = '0; bus.Funct = 6'b100000;
    #1;
    check("add_busy_stall", 64'(bus.o_stall), 64'd0);
    check("add_busy_ctrl", 64'(bus.ALUControl), 64'd0);
    bus.i_valid = 1'b0; bus.Funct = F_MFHI;
    #1;
    check("bubble_mfhi_stall", 64'(bus.o_stall), 64'd0);
    @(posedge clk); #1;
    bubble();
    read_both();

    exec(F_MTLO, 32'h0000_1234, '0, s);
    exec(F_MFLO, '0, '0, s);
    check("mtlo_mflo_stall", 64'(s), 64'd0);
    exec(F_MTHI, 32'hCAFE_F00D, '0, s);
    exec(F_MFHI, '0, '0, s);

    // Reset in busy cycle 10 abandons the multiply.
    exec(F_MULT, 32'h1234_5678, 32'h0000_0F00, s);
    repeat (9) @(posedge clk);
    #2;
    check("busy_before_reset", 64'(bus.o_busy), 64'd1);
    reset = 1'b1;
    #1;
    check("busy_on_reset", 64'(bus.o_busy), 64'd0);
    hi_m = '0; lo_m = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("busy_after_reset", 64'(bus.o_busy), 64'd0);
    read_both();

    // Decode.
    dcheck("dec_sub", 6'd0, 6'b100010, 6'd2);
    dcheck("dec_op16", 6'd16, 6'b000000, 6'd30);
    dcheck("dec_op3", 6'd3, 6'b100000, 6'd0);
    dcheck("dec_mult_zero", 6'd0, F_MULT, 6'd0);
    for (int k = 0; k < 60; k++) begin
      op = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 31));
      fn = ($urandom_range(0, 1) == 0) ? 6'(r_funct[$urandom_range(0, 13)]) : 6'($urandom);
      dcheck("dec_rand", op, fn, ref_ctrl(op, fn));
    end
    @(posedge clk); #1;
    bubble();

    // Random HI/LO traffic against the model.
    for (int k = 0; k < 30; k++) begin
      fn = ops[$urandom_range(0, 5)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      exec(fn, a, b, s);
      if ($urandom_range(0, 1) == 0) begin
        exec(F_MFHI, '0, '0, s);
        exec(F_MFLO, '0, '0, s);
      end else begin
        exec(F_MFLO, '0, '0, s);
        exec(F_MFHI, '0, '0, s);
      end
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("dbz_pulses_total", 64'(dbz_seen), 64'(dbz_exp));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_control_muldiv.md
# alu_control_muldiv

Execute-stage ALU control unit with an integrated iterative multiply/divide sequencer and HI/LO register pair, for the MIPS pipeline. It decodes `ALUOp`/`Funct` into the ALU control code and adds MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. Multiply and divide run in the background over `DATA_WIDTH` cycles. A combinational interlock stalls the pipeline only when a HI/LO-dependent instruction reaches EX while the sequencer is busy.

## Interface
- `DATA_WIDTH`, 32, operand, HI and LO width; must be ≥ 2.
- `OP_WIDTH`, 6, width of `ALUOp`, `Funct` and `ALUControl`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `i_valid`  in  1  EX stage holds a real instruction (not a bubble).
- `ALUOp`  in  OP_WIDTH  opcode class from the main controller.
- `Funct`  in  OP_WIDTH  instruction funct field.
- `i_rs`, `i_rt`  in  DATA_WIDTH each  forwarded operands.
- `ALUControl`  out  OP_WIDTH  ALU control code (combinational).
- `o_use_hilo`  out  1  EX result mux selects `o_hilo_data` (MFHI/MFLO).
- `o_hilo_data`  out  DATA_WIDTH  HI for MFHI, LO for MFLO, else 0.
- `o_stall`  out  1  hold IF/ID/EX and inject a bubble into MEM (combinational).
- `o_busy`  out  1  sequencer running (registered).
- `o_div_by_zero`  out  1  one-cycle pulse when a DIV/DIVU with divisor 0 completes.

## Operation

**ALU control decode (combinational)**
- ALUOp 0 with funct SLL/SRA/SLLV/SRAV/ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU gives codes 23/28/36/15/0/1/2/45/18/19/21/20/30/31.
- ALUOp 1/2/4/6/7/11/12/13/14/16/17/18/20 gives codes 1/0/17/9/10/14/18/19/21/30/31/24/37.
- ALUOp 0 with a HI/LO funct gives `ALUControl` = 0.
- Anything else gives 0.
- HI/LO functs are 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010010 MFLO, 010001 MTHI, 010011 MTLO.

**Issue condition**
- Define `hilo_op` = `i_valid` & ALUOp==0 & funct is one of the eight HI/LO functs.
- `o_stall` = `hilo_op` & `o_busy`. Non-HI/LO instructions never stall.
- An instruction issues when `hilo_op` & !`o_stall`.

**FSM states: IDLE, RUN**
- IDLE + issued MULT/MULTU/DIV/DIVU: latch operands and sign flags, clear counter, go to RUN.
- RUN: one shift-add step (multiply) or one restoring-subtract step (divide) per cycle.
- RUN ends when counter == DATA_WIDTH−1: write HI/LO, return to IDLE.

**Issued MTHI/MTLO**
- Write `i_rs` into HI/LO on the issuing edge; FSM stays in IDLE.

**Issued MFHI/MFLO**
- `o_use_hilo`=1; `o_hilo_data` = current HI/LO.

**Arithmetic**
- Internal datapath: 2·DATA_WIDTH product accumulator, DATA_WIDTH+1 remainder.
- Signed operations run on magnitudes; signs are applied on the final edge.
- Multiply result: HI = upper half, LO = lower half.
- Divide result: LO = quotient, HI = remainder. Quotient is negated when operand signs differ; remainder takes the dividend's sign.
- Divisor 0: LO = all ones, HI = dividend (unsigned magnitude for DIVU; sign-restored for DIV), `o_div_by_zero` pulses.
- DIV of −2^(W−1) by −1: LO = −2^(W−1), HI = 0 (wraps, no flag).

**Reset**
- HI=0, LO=0, state IDLE, counter 0, `o_busy`=0, `o_div_by_zero`=0.
- Reset mid-RUN abandons the operation; HI/LO do not update.

## Timing
- MULT/DIV issued in cycle t: `o_busy`=1 in cycles t+1..t+DATA_WIDTH.
- HI/LO update on the edge ending cycle t+DATA_WIDTH.
- First non-stalled MFHI/MFLO is in cycle t+DATA_WIDTH+1 and returns the new value.
- Back-to-back MULT in cycle t+1 stalls until t+DATA_WIDTH+1.
- `o_div_by_zero` is high in cycle t+DATA_WIDTH+1 only.
- MTHI/MTLO: one-cycle, visible to an MFHI/MFLO in the next cycle.
- `o_stall` with `i_valid`=0: stall stays 0; the sequencer continues regardless.

## Test plan
- MULT rs=0xFFFFFFFD (−3), rt=7; MFLO presented at t+1: `o_stall`=1 through t+32; at t+33 `o_hilo_data`=0xFFFFFFEB; MFHI returns 0xFFFFFFFF.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/0 → LO=0xFFFFFFFF, HI=7, one-cycle `o_div_by_zero`.
- DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Reset asserted mid-RUN at busy cycle 10: `o_busy` drops immediately; HI=LO=0; no late HI/LO write after release.
- Decode sweep: ALUOp 0 funct 100010 → 2; ALUOp 16 → 30; ALUOp 3 → 0. ADD issued during busy gives `o_stall`=0. MTLO 0x1234 then MFLO gives 0x1234 with no stall.
